pll_reset_sequencer: RTL and testbench

Upstream control stage for the 14x rPLL: owns the PLL's active-high RESET input, watches its LOCK output, and releases the system reset only after lock has been stable for a programmable time. Runs on the free-running 7.09 MHz input clock, the same clock that feeds the PLL. Recovers from lock loss automatically. Reports retry and lock-loss status for debug.

---
 rtl/pll_reset_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Reset controller that sits in front of the 14x rPLL. It pulses the PLL's
// active-high RESET input and watches the PLL LOCK output. The system reset
// is released only after lock has stayed high for a programmable number of
// cycles. If lock is lost, the controller restarts the sequence on its own.
// Runs on the free-running input clock that also feeds the PLL.
//
// Optional feature macro: SF_PLL_LOCK_TIMEOUT_EN
//   defined   : WAIT gives up after TIMEOUT_CYCLES, re-pulses the PLL reset and
//               counts the event in a saturating 'retries' counter.
//   undefined : WAIT waits for lock indefinitely and 'retries' is tied to 0.
//
// Ports
//   clk          in   free-running input clock (PLL clkin)
//   reset_n      in   asynchronous active-low reset
//   pll_lock     in   PLL LOCK, asynchronous; synchronized internally
//   pll_restart  in   single-cycle synchronous request to restart the PLL
//   pll_reset    out  PLL RESET, active-high, high only in RST
//   sys_reset_n  out  active-low reset for the PLL clock domains, high only in RUN
//   locked       out  high only in RUN
//   retries      out  saturating count of lock timeouts (4 bits)
//   lock_lost    out  sticky flag, set when lock drops while in RUN
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       pll_restart,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       locked,
  output logic [3:0] retries,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    S_RST    = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Elaboration-time guard on the parameter ranges the counter can honour.
  if ((RST_CYCLES < 2) || (STABLE_CYCLES < 1) || (TIMEOUT_CYCLES < 1) ||
      (CNT_W < 1) || (CNT_W < 31 && RST_CYCLES > (1 << CNT_W)) ||
      (CNT_W < 31 && STABLE_CYCLES > (1 << CNT_W))) begin : g_bad_params
    $error("pll_reset_sequencer: parameter out of legal range");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, lock_s_q;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_reset_q, sys_reset_n_q, locked_q;
  logic             restart_pulse;

`ifdef SF_PLL_LOCK_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [3:0] retries_q, retries_d;
`endif

  // ---- lock synchronizer ----------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= pll_lock;
      lock_s_q <= sync1_q;
    end
  end

  // ---- next-state / status logic --------------------------------------------
  always_comb begin
    state_d       = state_q;
    lock_lost_d   = lock_lost_q;
    restart_pulse = 1'b0;
`ifdef SF_PLL_LOCK_TIMEOUT_EN
    retries_d     = retries_q;
`endif
    if (pll_restart) begin
      // Restart beats every other transition and must also restart a pulse
      // already in progress, so the counter is cleared even when RST -> RST.
      state_d       = S_RST;
      restart_pulse = 1'b1;
    end else begin
      unique case (state_q)
        S_RST: begin
          if (cnt_q == RST_LAST) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
`ifdef SF_PLL_LOCK_TIMEOUT_EN
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_RST;
            if (retries_q != 4'hF) retries_d = retries_q + 4'd1;
`endif
          end
        end
        S_STABLE: begin
          if (!lock_s_q)                state_d = S_WAIT;
          else if (cnt_q == STABLE_LAST) state_d = S_RUN;
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d     = S_RST;
            lock_lost_d = 1'b1;
          end
        end
        default: state_d = S_RST;
      endcase
    end

    if ((state_d != state_q) || restart_pulse) cnt_d = '0;
    else                                       cnt_d = cnt_q + 1'b1;
  end

  // ---- state, counter and registered outputs --------------------------------
  // Outputs are flops loaded from the next state, so they always equal a
  // decode of the current state without any combinational glitching.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_RST;
      cnt_q         <= '0;
      lock_lost_q   <= 1'b0;
      pll_reset_q   <= 1'b1;
      sys_reset_n_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      lock_lost_q   <= lock_lost_d;
      pll_reset_q   <= (state_d == S_RST);
      sys_reset_n_q <= (state_d == S_RUN);
      locked_q      <= (state_d == S_RUN);
    end
  end

`ifdef SF_PLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) retries_q <= 4'd0;
    else          retries_q <= retries_d;
  end
  assign retries = retries_q;
`else
  assign retries = 4'd0;
`endif

  assign pll_reset   = pll_reset_q;
  assign sys_reset_n = sys_reset_n_q;
  assign locked      = locked_q;
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Scoreboard bench for pll_reset_sequencer. Each scenario plans its stimulus
// times, pushes the expected output vector for selected cycles (counted in
// rising edges since reset_n release) into a queue, then drives the stimulus.
// A negedge monitor pops entries as their cycle comes up and compares.
// Output vector: {pll_reset, sys_reset_n, locked, lock_lost, retries[3:0]}.
// Build with +define+SF_PLL_LOCK_TIMEOUT_EN to add the timeout scenario.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int RST_CYCLES     = 16;
  localparam int STABLE_CYCLES  = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CNT_W          = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_restart = 1'b0;
  logic       pll_reset;
  logic       sys_reset_n;
  logic       locked;
  logic [3:0] retries;
  logic       lock_lost;

  pll_reset_sequencer #(
    .RST_CYCLES    (RST_CYCLES),
    .STABLE_CYCLES (STABLE_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_lock   (pll_lock),
    .pll_restart(pll_restart),
    .pll_reset  (pll_reset),
    .sys_reset_n(sys_reset_n),
    .locked     (locked),
    .retries    (retries),
    .lock_lost  (lock_lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         cyc;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] obs;

  assign obs = {pll_reset, sys_reset_n, locked, lock_lost, retries};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, got, want, $time);
  endtask

  function automatic logic [7:0] vec(input bit pr, input bit sr, input bit lk,
                                     input bit ll, input logic [3:0] rt);
    return {pr, sr, lk, ll, rt};
  endfunction

  task automatic expect_at(input int c, input string tag, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  // Rising edges since reset_n release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (reset_n) begin
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        mon_e = sb_q.pop_front();
        if (mon_e.cyc == cyc) check_eq(mon_e.tag, 32'(obs), 32'(mon_e.exp));
        else check_eq({mon_e.tag, "_missed"}, cyc, mon_e.cyc);
      end
    end
  end

  // Inputs change 2 time units after a rising edge, so "driven at cycle n"
  // means first seen by the DUT on edge n+1.
  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb_q.size() > 0 && n < 5000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_eq(tag, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n     = 1'b0;
    pll_lock    = 1'b0;
    pll_restart = 1'b0;
    #1;
    check_eq(tag, 32'(obs), 32'(vec(1, 0, 0, 0, 4'd0)));
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-up, lock loss in RUN, reacquire, async reset mid-STABLE.
    do_reset("rst_vals_pwr");
    expect_at(0,   "pwr_prst_c0",     vec(1, 0, 0, 0, 4'd0));
    expect_at(15,  "pwr_prst_c15",    vec(1, 0, 0, 0, 4'd0));
    expect_at(16,  "pwr_wait_c16",    vec(0, 0, 0, 0, 4'd0));
    expect_at(50,  "pwr_stable_c50",  vec(0, 0, 0, 0, 4'd0));
    expect_at(51,  "pwr_run_c51",     vec(0, 1, 1, 0, 4'd0));
    expect_at(62,  "loss_run_c62",    vec(0, 1, 1, 0, 4'd0));
    expect_at(63,  "loss_rst_c63",    vec(1, 0, 0, 1, 4'd0));
    expect_at(78,  "loss_prst_c78",   vec(1, 0, 0, 1, 4'd0));
    expect_at(79,  "loss_wait_c79",   vec(0, 0, 0, 1, 4'd0));
    expect_at(95,  "reacq_c95",       vec(0, 0, 0, 1, 4'd0));
    expect_at(96,  "reacq_run_c96",   vec(0, 1, 1, 1, 4'd0));
    expect_at(121, "mid_stable_c121", vec(0, 0, 0, 1, 4'd0));
    step_to(40);  pll_lock = 1'b1;
    step_to(60);  pll_lock = 1'b0;
    step_to(85);  pll_lock = 1'b1;
    step_to(100); pll_lock = 1'b0;
    step_to(110); pll_lock = 1'b1;
    step_to(122);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_mid_stable", 32'(obs), 32'(vec(1, 0, 0, 0, 4'd0)));
    drain("sb_drained_pwr");

    // Lock bounce in STABLE: full stable count restarts, no retry counted.
    do_reset("rst_vals_bnc");
    expect_at(22, "bnc_wait_c22",     vec(0, 0, 0, 0, 4'd0));
    expect_at(30, "bnc_c30",          vec(0, 0, 0, 0, 4'd0));
    expect_at(31, "bnc_no_run_c31",   vec(0, 0, 0, 0, 4'd0));
    expect_at(40, "bnc_c40",          vec(0, 0, 0, 0, 4'd0));
    expect_at(41, "bnc_run_c41",      vec(0, 1, 1, 0, 4'd0));
    step_to(20); pll_lock = 1'b1;
    step_to(27); pll_lock = 1'b0;
    step_to(30); pll_lock = 1'b1;
    step_to(45);
    drain("sb_drained_bnc");

    // Restart in RUN on the cycle lock_s falls: one RST entry, lock_lost stays 0.
    do_reset("rst_vals_rsr");
    expect_at(41, "rsr_run_c41",      vec(0, 1, 1, 0, 4'd0));
    expect_at(42, "rsr_run_c42",      vec(0, 1, 1, 0, 4'd0));
    expect_at(43, "rsr_rst_c43",      vec(1, 0, 0, 0, 4'd0));
    expect_at(58, "rsr_prst_c58",     vec(1, 0, 0, 0, 4'd0));
    expect_at(59, "rsr_wait_c59",     vec(0, 0, 0, 0, 4'd0));
    expect_at(70, "rsr_once_c70",     vec(0, 0, 0, 0, 4'd0));
    step_to(20); pll_lock = 1'b1;
    step_to(40); pll_lock = 1'b0;
    step_to(42); pll_restart = 1'b1;
    step_to(43); pll_restart = 1'b0;
    step_to(72);
    drain("sb_drained_rsr");

    // Restart while already in RST stretches the pulse from the restart edge.
    do_reset("rst_vals_rrr");
    expect_at(6,  "rrr_prst_c6",      vec(1, 0, 0, 0, 4'd0));
    expect_at(16, "rrr_prst_c16",     vec(1, 0, 0, 0, 4'd0));
    expect_at(21, "rrr_prst_c21",     vec(1, 0, 0, 0, 4'd0));
    expect_at(22, "rrr_wait_c22",     vec(0, 0, 0, 0, 4'd0));
    step_to(5); pll_restart = 1'b1;
    step_to(6); pll_restart = 1'b0;
    step_to(25);
    drain("sb_drained_rrr");

`ifdef SF_PLL_LOCK_TIMEOUT_EN
    // Timeout with lock never asserted: re-pulse every RST+TIMEOUT cycles,
    // retries saturates at 15, then an async reset clears it.
    do_reset("rst_vals_to");
    for (int k = 1; k <= 17; k++) begin
      int per = RST_CYCLES + TIMEOUT_CYCLES;
      logic [3:0] r_pre  = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
      logic [3:0] r_post = (k > 15) ? 4'd15 : 4'(k);
      expect_at(per * k - 1, $sformatf("to_wait_%0d", k), vec(0, 0, 0, 0, r_pre));
      expect_at(per * k,     $sformatf("to_rst_%0d", k),  vec(1, 0, 0, 0, r_post));
    end
    step_to((RST_CYCLES + TIMEOUT_CYCLES) * 17 + 2);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_clears_retries", 32'(obs), 32'(vec(1, 0, 0, 0, 4'd0)));
    drain("sb_drained_to");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
